// File: rtl/detect_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | detect_pkg: shared state encoding and helpers for the event counter.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package detect_pkg;

  typedef logic [1:0] state_t;

  localparam state_t c_ST_IDLE   = 2'd0;
  localparam state_t c_ST_COUNT  = 2'd1;
  localparam state_t c_ST_REPORT = 2'd2;

  // Saturation ceiling of a w-bit counter.
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rise_detect: flags the first cycle of each high period on d.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic r_f_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_f_q <= 1'b0;
    else        r_f_q <= d;
  end

  assign rise = d & ~r_f_q;

endmodule
`default_nettype wire

// File: rtl/detect_event_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | detect_event_counter: counts rising edges of F over tumbling windows,    |
// | reports per-window totals and raises a sticky threshold alarm.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module detect_event_counter
  import detect_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16,
  parameter int THRESH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             F,
  input  logic             clear,
  output logic             event_pulse,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] last_count,
  output logic             window_done,
  output logic             alarm
);

  localparam int               c_WIN_W    = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] c_THRESH   = CNT_W'(THRESH);
  localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(WINDOW - 1);

  state_t             r_state, w_state_next;
  logic [c_WIN_W-1:0] r_win_cnt, w_win_next;
  logic [CNT_W-1:0]   r_count, w_count_next, w_count_inc;
  logic [CNT_W-1:0]   r_last_count, w_last_next;
  logic               r_event_pulse, r_window_done, r_alarm, w_wd_next;
  logic               w_rise;

  rise_detect u_rise (
    .clock (clock),
    .reset (reset),
    .d     (F),
    .rise  (w_rise)
  );

  assign w_count_inc = (r_count == c_CNT_MAX) ? r_count : r_count + CNT_W'(1);

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_win_next   = r_win_cnt;
    w_last_next  = r_last_count;
    w_wd_next    = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        w_count_next = '0;
        w_win_next   = '0;
        if (enable) w_state_next = c_ST_COUNT;
      end
      c_ST_COUNT: begin
        if (!enable) begin
          w_state_next = c_ST_IDLE;
          w_count_next = '0;
          w_win_next   = '0;
        end else begin
          w_count_next = w_rise ? w_count_inc : r_count;
          if (r_win_cnt == c_WIN_LAST) begin
            w_state_next = c_ST_REPORT;
            w_win_next   = '0;
            w_last_next  = w_count_next;
            w_wd_next    = 1'b1;
          end else begin
            w_win_next = r_win_cnt + c_WIN_W'(1);
          end
        end
      end
      c_ST_REPORT: begin
        // A rise during the report cycle seeds the next window.
        w_win_next = '0;
        if (enable) begin
          w_state_next = c_ST_COUNT;
          w_count_next = CNT_W'(w_rise);
        end else begin
          w_state_next = c_ST_IDLE;
          w_count_next = '0;
        end
      end
      default: begin
        w_state_next = c_ST_IDLE;
        w_count_next = '0;
        w_win_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= c_ST_IDLE;
      r_win_cnt     <= '0;
      r_count       <= '0;
      r_last_count  <= '0;
      r_event_pulse <= 1'b0;
      r_window_done <= 1'b0;
      r_alarm       <= 1'b0;
    end else if (clear) begin
      r_state       <= c_ST_IDLE;
      r_win_cnt     <= '0;
      r_count       <= '0;
      r_last_count  <= '0;
      r_event_pulse <= 1'b0;
      r_window_done <= 1'b0;
      r_alarm       <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_win_cnt     <= w_win_next;
      r_count       <= w_count_next;
      r_last_count  <= w_last_next;
      r_event_pulse <= w_rise;
      r_window_done <= w_wd_next;
      if (w_count_next >= c_THRESH) r_alarm <= 1'b1;
    end
  end

  assign event_pulse = r_event_pulse;
  assign count       = r_count;
  assign last_count  = r_last_count;
  assign window_done = r_window_done;
  assign alarm       = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_detect_event_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_detect_event_counter: vector table, directed corner sequences and     |
// | randomized traffic against a cycle-level reference model.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_detect_event_counter;

  localparam int WINDOW = 16;
  localparam int THRESH = 3;
  localparam int MD_IDLE = 0, MD_RUN = 1, MD_REP = 2;

  logic clock = 1'b0;
  logic reset, enable, F, clear;
  logic       ev0, wd0, al0, ev1, wd1, al1;
  logic [7:0] cnt0, last0;
  logic [1:0] cnt1, last1;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  detect_event_counter #(.CNT_W(8), .WINDOW(WINDOW), .THRESH(THRESH)) dut (
    .clock(clock), .reset(reset), .enable(enable), .F(F), .clear(clear),
    .event_pulse(ev0), .count(cnt0), .last_count(last0),
    .window_done(wd0), .alarm(al0)
  );

  detect_event_counter #(.CNT_W(2), .WINDOW(WINDOW), .THRESH(THRESH)) dut_sat (
    .clock(clock), .reset(reset), .enable(enable), .F(F), .clear(clear),
    .event_pulse(ev1), .count(cnt1), .last_count(last1),
    .window_done(wd1), .alarm(al1)
  );

  // Reference model: mode plus elapsed window cycles and an event tally.
  typedef struct {
    int mode; int cyc; int cnt; int last; bit ev; bit wd; bit alarm;
  } mdl_t;
  mdl_t m[2];
  int   mx[2];
  bit   m_fprev;

  typedef struct {
    bit en; bit f; bit clr; bit ev; int cnt; int last; bit wd; bit al;
  } vec_t;
  vec_t tv[18];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fprev = 1'b0;
    for (int i = 0; i < 2; i++) m[i] = '{default: 0};
  endtask

  task automatic model_edge(input bit en, input bit f, input bit clr);
    bit rise;
    rise    = f && !m_fprev;
    m_fprev = f;
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        m[i] = '{default: 0};
      end else begin
        m[i].ev = rise;
        m[i].wd = 1'b0;
        case (m[i].mode)
          MD_IDLE: begin
            m[i].cnt = 0;
            if (en) begin m[i].mode = MD_RUN; m[i].cyc = 0; end
          end
          MD_RUN: begin
            if (!en) begin
              m[i].mode = MD_IDLE; m[i].cnt = 0;
            end else begin
              if (rise && m[i].cnt < mx[i]) m[i].cnt++;
              m[i].cyc++;
              if (m[i].cyc == WINDOW) begin
                m[i].mode = MD_REP; m[i].last = m[i].cnt; m[i].wd = 1'b1;
              end
            end
          end
          default: begin
            if (en) begin m[i].mode = MD_RUN; m[i].cyc = 0; m[i].cnt = rise ? 1 : 0; end
            else begin m[i].mode = MD_IDLE; m[i].cnt = 0; end
          end
        endcase
        if (m[i].cnt >= THRESH) m[i].alarm = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    chk("ev0", ev0, m[0].ev);     chk("cnt0", cnt0, m[0].cnt);
    chk("last0", last0, m[0].last); chk("wd0", wd0, m[0].wd);
    chk("al0", al0, m[0].alarm);
    chk("ev1", ev1, m[1].ev);     chk("cnt1", cnt1, m[1].cnt);
    chk("last1", last1, m[1].last); chk("wd1", wd1, m[1].wd);
    chk("al1", al1, m[1].alarm);
  endtask

  task automatic step();
    @(posedge clock);
    if (reset) model_edge(enable, F, clear);
    #1;
    compare_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ev0"}, ev0, 0);   chk({tag, "_cnt0"}, cnt0, 0);
    chk({tag, "_last0"}, last0, 0); chk({tag, "_wd0"}, wd0, 0);
    chk({tag, "_al0"}, al0, 0);   chk({tag, "_cnt1"}, cnt1, 0);
    chk({tag, "_last1"}, last1, 0); chk({tag, "_al1"}, al1, 0);
  endtask

  // Called just after an active edge; reset asserts mid-cycle.
  task automatic async_reset();
    #2 reset = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    @(negedge clock);
    #2 reset = 1'b1;
  endtask

  task automatic run_window(input bit toggle, output int evs);
    bit seen;
    evs  = 0;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (toggle) F = ~F;
      step();
      evs += int'(ev0);
      seen = wd0;
    end
    if (!seen) chk("window_done_timeout", 0, 1);
  endtask

  task automatic run_to_last();
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 40 && !hit; n++) begin
      if (m[0].mode == MD_RUN && m[0].cyc == WINDOW - 1) hit = 1'b1;
      else step();
    end
    if (!hit) chk("window_end_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int evs, wds;
    mx[0] = 255;
    mx[1] = 3;
    reset = 1'b0; enable = 1'b0; F = 1'b0; clear = 1'b0;
    model_reset();
    #2 check_zero("reset");
    @(negedge clock);
    #2 reset = 1'b1;

    // Basic window: pulses at edges 3 and 9, report after edge 16.
    for (int k = 0; k < 18; k++) begin
      tv[k].en   = 1'b1;
      tv[k].f    = (k == 3 || k == 9);
      tv[k].clr  = 1'b0;
      tv[k].ev   = (k == 3 || k == 9);
      tv[k].cnt  = (k < 3) ? 0 : (k < 9) ? 1 : (k < 17) ? 2 : 0;
      tv[k].last = (k < 16) ? 0 : 2;
      tv[k].wd   = (k == 16);
      tv[k].al   = 1'b0;
    end
    for (int k = 0; k < 18; k++) begin
      enable = tv[k].en; F = tv[k].f; clear = tv[k].clr;
      step();
      chk($sformatf("tv%0d_ev", k), ev0, tv[k].ev);
      chk($sformatf("tv%0d_cnt", k), cnt0, tv[k].cnt);
      chk($sformatf("tv%0d_last", k), last0, tv[k].last);
      chk($sformatf("tv%0d_wd", k), wd0, tv[k].wd);
      chk($sformatf("tv%0d_al", k), al0, tv[k].al);
    end

    // Alarm on the third rise, sticky across a quiet window, cleared by clear.
    F = 1'b1; step(); chk("alarm_pre", al0, 0); chk("alarm_cnt1", cnt0, 1);
    F = 1'b0; step(); F = 1'b1; step(); F = 1'b0; step();
    F = 1'b1; step(); chk("alarm_set", al0, 1); chk("alarm_cnt3", cnt0, 3);
    F = 1'b0;
    run_window(1'b0, evs); chk("alarm_last3", last0, 3);
    run_window(1'b0, evs); chk("alarm_sticky", al0, 1); chk("quiet_last", last0, 0);
    clear = 1'b1; step(); clear = 1'b0;
    chk("clear_al", al0, 0); chk("clear_last", last0, 0); chk("clear_cnt", cnt0, 0);

    // Long F high gives a single event.
    step();
    evs = 0;
    F = 1'b1;
    for (int n = 0; n < 10; n++) begin step(); evs += int'(ev0); end
    F = 1'b0;
    run_window(1'b0, wds);
    chk("held_events", evs + wds, 1); chk("held_last", last0, 1);

    // Toggling F saturates the narrow counter.
    run_window(1'b1, evs);
    chk("sat_last1", last1, 3); chk("sat_cnt1", cnt1, 3);
    chk("wide_last0_gt3", int'(last0 > 8'd3), 1);

    // Rise on the closing edge is included in the report.
    F = 1'b0; step();
    run_to_last();
    F = 1'b1; step();
    chk("close_wd", wd0, 1); chk("close_last", last0, 1); chk("close_ev", ev0, 1);
    F = 1'b0; step();
    run_to_last();
    step(); chk("quiet_close_last", last0, 0);
    F = 1'b1; step(); chk("seed_cnt", cnt0, 1); chk("seed_ev", ev0, 1);
    F = 1'b0;
    run_window(1'b0, evs); chk("seed_last", last0, 1);

    // Enable drop mid-window.
    for (int k = 0; k < 8; k++) begin F = (k == 3); step(); end
    chk("pre_drop_cnt", cnt0, 1);
    enable = 1'b0; F = 1'b0; step();
    chk("drop_cnt", cnt0, 0); chk("drop_wd", wd0, 0); chk("drop_last", last0, 1);
    wds = 0;
    for (int n = 0; n < 20; n++) begin step(); wds += int'(wd0); end
    chk("idle_no_wd", wds, 0); chk("idle_last", last0, 1);

    // Async reset mid-window, then F high across release.
    enable = 1'b1; step();
    F = 1'b1; step(); F = 1'b0; step(); F = 1'b1; step();
    chk("pre_rst_cnt", cnt0, 2);
    async_reset();
    step(); chk("release_ev", ev0, 1); chk("release_cnt", cnt0, 0);

    // Clear coinciding with a rise.
    F = 1'b0; step();
    F = 1'b1; clear = 1'b1; step(); chk("clr_rise_ev", ev0, 0); chk("clr_rise_cnt", cnt0, 0);
    clear = 1'b0; step(); chk("clr_held_ev", ev0, 0);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      enable = ($urandom_range(0, 15) != 0);
      F      = ($urandom_range(0, 4) < 2);
      clear  = ($urandom_range(0, 199) == 0);
      step();
      if ($urandom_range(0, 399) == 0) async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/detect_event_counter.md
Name: detect_event_counter

Overview:
Downstream consumer of the sequence-detector FSM's output F. It converts the level-style match flag into single-cycle events and counts them over fixed tumbling windows of WINDOW cycles. At the end of each window it reports the total, and it raises a sticky alarm when the in-window count reaches THRESH. Results feed status registers and interrupt logic.

Parameters:
- CNT_W, 8: width of event counters. Counters saturate at 2^CNT_W-1.
- WINDOW, 16: COUNT-state length in cycles. Legal range: WINDOW >= 2.
- THRESH, 3: in-window event count that sets alarm. Legal range: 1 <= THRESH <= 2^CNT_W-1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; all state cleared while low.
- enable  in  1  run windows while high.
- F  in  1  match flag from the upstream detector FSM; level signal, may stay high for several cycles.
- clear  in  1  synchronous clear of counts, alarm and state.
- event_pulse  out  1  one-cycle strobe per rising edge of F.
- count  out  CNT_W  running count for the current window.
- last_count  out  CNT_W  total from the most recently completed window.
- window_done  out  1  one-cycle strobe when last_count is updated.
- alarm  out  1  sticky threshold flag.

Behaviour:
- Reset (reset=0, asynchronous, active-low):
  - state=IDLE; f_q, count, last_count, win_cnt all 0.
  - event_pulse, window_done and alarm all 0.
- Edge detect, every edge, all states:
  - rise = F & ~f_q; f_q <= F; event_pulse <= rise.
  - F held high for N cycles yields exactly one rise.
  - F high at reset release counts as a rise.
- Priority at each edge: clear > enable drop > normal operation.
- IDLE:
  - count=0, win_cnt=0.
  - enable=1 → COUNT with win_cnt=0.
  - Rises in IDLE are not counted.
- COUNT:
  - win_cnt increments each edge.
  - On rise, count <= min(count+1, 2^CNT_W-1).
  - When win_cnt==WINDOW-1, next edge → REPORT. This gives exactly WINDOW cycles in COUNT.
- Transition COUNT→REPORT:
  - last_count <= count_next, which includes a rise at that same edge.
  - window_done=1 for the single REPORT cycle.
- REPORT (1 cycle):
  - count <= rise, so an event in the REPORT cycle seeds the next window; no events are lost.
  - win_cnt <= 0.
  - enable=1 → COUNT; else → IDLE with count <= 0.
  - Continuous enable gives a period of WINDOW+1 cycles.
- alarm:
  - Set at the edge where count_next >= THRESH in COUNT or REPORT.
  - Held until clear or reset; never self-clears across windows.
- enable drops in COUNT:
  - → IDLE at that edge; count <= 0.
  - last_count unchanged; no window_done.
- clear=1:
  - → IDLE; count, last_count, win_cnt, alarm <= 0; event_pulse <= 0.
  - f_q still samples F, so a held-high F is not re-counted.
- Saturation: count holds at max. last_count may report the saturated value.
- win_cnt width is $clog2(WINDOW).
- All outputs are registered; no combinational paths from inputs to outputs.

Decomposition:
- Package detect_pkg:
  - state encoding for IDLE/COUNT/REPORT, 2-bit enum.
  - localparam CNT_MAX = 2^CNT_W-1 helper.
- Sub-module rise_detect:
  - ports: clock, reset, d, rise.
  - holds f_q; reused for other detector outputs.

Test Plan:
1. Defaults; enable=1 at edge 0; F one-cycle pulses at edges 3 and 9 → event_pulse twice, window_done in cycle after edge 16, last_count=2, alarm=0.
2. Three single-cycle F pulses in one window → alarm=1 at the third rise edge; alarm stays 1 through the next window with zero events; clear=1 → alarm=0, last_count=0, state IDLE.
3. F held high for 10 cycles inside the window → count=1, last_count=1; one event_pulse only.
4. CNT_W=2, F toggling every cycle, WINDOW=16 → count saturates at 3; last_count=3.
5. Rise at the REPORT edge:
   - window 1 ends with count=1 → last_count=1.
   - F rise landing in the REPORT cycle → next window's count starts at 1.
6. Mid-window events:
   - enable=0 at edge 8 → IDLE, no window_done, last_count keeps prior value.
   - reset low at edge 5 with count=2 → all outputs 0 immediately, before the next clock edge.
   - clear coinciding with a rise → count=0, event_pulse=0.
